endscreen_vga_ctrl: RTL and testbench
=====================================

Name: endscreen_vga_ctrl

Overview:
Parametrised end-of-game screen engine with its own VGA timing (pixel-tick divider, h/v counters) and a sequenced result display.
- Latches the game result and scores on entry.
- Blinks a result-coloured banner and draws score bars.
- Leaves after a frame-counted timeout or a home request, then signals `done` to the top-level game FSM.

Parameters:
- CLK_DIV, 4: clk_100MHz cycles per pixel tick (≥2).
- H_DISPLAY, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_DISPLAY, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- BLINK_FRAMES, 30: frames per banner on/off phase.
- TIMEOUT_FRAMES, 600: frames in SHOW before auto exit.
- SCORE_W, 4: score width.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  end-screen selected by the game FSM.
- win  in  1  player won (level).
- lose  in  1  player lost (level).
- home  in  1  synchronous, debounced home request (level).
- score_l  in  SCORE_W  left score.
- score_r  in  SCORE_W  right score.
- rgb  out  12  pixel colour {R4,G4,B4}.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- video_on  out  1  registered visible-area flag.
- frame_tick  out  1  one-clock pulse at each frame wrap.
- done  out  1  one-clock pulse on exit.

Behaviour:
Reset:
- All outputs are 0, except hsync=vsync=1.
- Counters and divider are 0; FSM is in IDLE.

Pixel tick:
- The divider counts 0..CLK_DIV-1.
- p_tick is high for one clock when the divider equals CLK_DIV-1.

Timing counters:
- x counts 0..H_TOTAL-1 on p_tick, where H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800).
- On x wrap, y increments through 0..V_TOTAL-1 (525).
- frame_tick pulses on the p_tick where (x,y) goes from (H_TOTAL-1,V_TOTAL-1) to (0,0).

Sync and visibility:
- hsync is low for x in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. 656..751.
- vsync is low for y in 490..491.
- video_on = (x<H_DISPLAY && y<V_DISPLAY).

Output registration and latency:
- rgb, hsync, vsync and video_on are registered and update only on p_tick.
- Latency from counter value to output is one pixel (CLK_DIV clocks).
- rgb is 12'h000 whenever video_on is 0.

FSM states: IDLE, SHOW, EXIT.
- IDLE:
  - rgb = 0 in the visible area.
  - On an enable rising edge, latch the result and scores, clear frame_cnt, set blink_on=1, go to SHOW.
  - Result latch: win&!lose → WIN; lose&!win → LOSE; both or neither → DRAW.
- SHOW, per frame_tick:
  - frame_cnt increments.
  - Every BLINK_FRAMES frames, blink_on toggles.
- SHOW, exit conditions (checked on every clock, not only frame_tick):
  - frame_cnt==TIMEOUT_FRAMES-1 at a frame_tick → EXIT.
  - home==1 → EXIT.
  - enable==0 → IDLE immediately, with no done pulse.
  - If home and enable deassert together, enable wins (→ IDLE, no done).
- EXIT:
  - done=1 for exactly one clock, then IDLE.
  - A new session requires enable to fall and rise again.

Drawing in SHOW (priority top to bottom):
- Banner: x 160..479, y 200..279. When blink_on is set, colour is WIN 12'h0F0, LOSE 12'hF00, DRAW 12'hFF0. When blink_on is clear, the banner shows background.
- Left score bar: y 320..335, x 160..160+8*score_l-1, colour 12'hFFF.
- Right score bar: y 320..335, x 480-8*score_r..479, colour 12'hFFF.
- Background: 12'h008.

Latched values:
- Scores and result latched at entry are used for the whole session.
- Input changes during SHOW are ignored.

Reset mid-SHOW:
- Returns immediately to reset values.
- No done pulse.

Optional Feature:
ENDSCREEN_BORDER_EN:
- Defined: in SHOW, an 8-pixel white (12'hFFF) frame is drawn at x<8, x≥632, y<8 or y≥472. It has top priority, above the banner.
- Undefined: no border logic is synthesised, and those pixels follow the normal drawing rules.

Test Plan:
1. Reset, then release and run 2 frames:
   - First frame_tick at clock 4*800*525 = 1,680,000 after reset release.
   - hsync low for 96*4 clocks per line.
   - vsync low for 2 lines per frame.
2. Pulse enable with win=1, lose=0, score_l=3, score_r=5:
   - Pixel (200,240) = 12'h0F0.
   - Pixel (180,328) = 12'hFFF.
   - Pixel (190,328) = 12'h008.
   - Pixel (440,328) = 12'hFFF.
3. Enable with win=lose=1:
   - Banner = 12'hFF0 in frames 0..29.
   - Banner = 12'h008 in frames 30..59.
   - Banner = 12'hFF0 again in frame 60.
4. Stay in SHOW with TIMEOUT_FRAMES=4:
   - done pulses once, one clock after the 4th frame_tick.
   - The next frame is blank.
5. Assert home in frame 2:
   - done pulses once.
   - Holding enable high afterwards does not restart the session.
   - Toggling enable low→high restarts it with freshly latched scores.
6. Deassert enable mid-SHOW, or assert reset mid-SHOW:
   - Immediate blank output.
   - done stays 0.
   - With ENDSCREEN_BORDER_EN defined, pixel (3,100) = 12'hFFF in SHOW.

Source files
------------

// File: rtl/endscreen_vga_ctrl.sv
// endscreen_vga_ctrl
//   End-of-game screen engine with its own VGA timing generator. On an
//   enable rising edge it latches the game result and both scores, then
//   draws a blinking result-coloured banner plus two score bars. It leaves
//   after TIMEOUT_FRAMES frames or on a home request and pulses done once.
//   If enable drops while showing, it returns to idle without done.
//
// Ports
//   clk_100MHz  system clock
//   reset       asynchronous, active-high reset
//   enable      end-screen selected by the game FSM (rising edge starts a session)
//   win, lose   result levels, sampled once at session entry
//   home        debounced home request (level), leaves the screen
//   score_l/r   scores, sampled once at session entry
//   rgb         pixel colour {R4,G4,B4}, registered, zero outside the visible area
//   hsync/vsync active-low syncs, registered
//   video_on    registered visible-area flag
//   frame_tick  one-clock pulse on the pixel tick that wraps (x,y) to (0,0)
//   done        one-clock pulse when the session exits through timeout or home
//
// Build option
//   ENDSCREEN_BORDER_EN : when defined, an 8-pixel white frame is drawn on
//   top of everything while showing.
//
// The banner/bar geometry and the bar unit width are parameters so that the
// drawing can follow a reduced display geometry; the defaults give the
// 640x480 layout.

module endscreen_vga_ctrl #(
  parameter int CLK_DIV        = 4,
  parameter int H_DISPLAY      = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_DISPLAY      = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int BLINK_FRAMES   = 30,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int SCORE_W        = 4,
  parameter int BANNER_X0      = 160,
  parameter int BANNER_X1      = 479,
  parameter int BANNER_Y0      = 200,
  parameter int BANNER_Y1      = 279,
  parameter int BAR_Y0         = 320,
  parameter int BAR_Y1         = 335,
  parameter int BAR_UNIT       = 8,
  parameter int BORDER_W       = 8
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               enable,
  input  logic               win,
  input  logic               lose,
  input  logic               home,
  input  logic [SCORE_W-1:0] score_l,
  input  logic [SCORE_W-1:0] score_r,
  output logic [11:0]        rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_tick,
  output logic               done
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int FW      = $clog2(TIMEOUT_FRAMES + 1);
  localparam int BW      = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_EXIT} state_t;
  typedef enum logic [1:0] {RES_WIN, RES_LOSE, RES_DRAW} result_t;

  logic [DW-1:0]      div_q, div_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  state_t             state_q, state_d;
  result_t            res_q, res_d;
  logic               en_q, en_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;

  logic        p_tick, x_end, y_end;
  logic [15:0] px, py, bar_l_end, bar_r_start;
  logic        visible, in_banner, in_bar_row, in_bar_l, in_bar_r, in_border;
  logic [11:0] banner_rgb;

  // ---------------- timing ----------------
  assign p_tick     = (div_q == DW'(CLK_DIV - 1));
  assign x_end      = (x_q == XW'(H_TOTAL - 1));
  assign y_end      = (y_q == YW'(V_TOTAL - 1));
  assign frame_tick = p_tick & x_end & y_end;

  always_comb begin
    div_d = p_tick ? '0 : div_q + DW'(1);
    x_d   = x_q;
    y_d   = y_q;
    if (p_tick) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // ---------------- session FSM ----------------
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    en_d        = enable;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    case (state_q)
      S_IDLE: begin
        // Only a fresh rising edge starts a session, so holding enable
        // high after an exit keeps the screen idle.
        if (enable && !en_q) begin
          if (win && !lose)      res_d = RES_WIN;
          else if (lose && !win) res_d = RES_LOSE;
          else                   res_d = RES_DRAW;
          score_l_d   = score_l;
          score_r_d   = score_r;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
          state_d     = S_SHOW;
        end
      end
      S_SHOW: begin
        // Losing enable beats every other exit and never produces done.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (home) begin
          state_d = S_EXIT;
        end else if (frame_tick) begin
          if (frame_cnt_q == FW'(TIMEOUT_FRAMES - 1)) begin
            state_d = S_EXIT;
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end
      end
      S_EXIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- drawing ----------------
  always_comb begin
    px          = 16'(x_q);
    py          = 16'(y_q);
    bar_l_end   = 16'(BANNER_X0) + 16'(BAR_UNIT) * 16'(score_l_q);
    // A zero score puts the start one past the banner edge: empty bar.
    bar_r_start = 16'(BANNER_X1 + 1) - 16'(BAR_UNIT) * 16'(score_r_q);
  end

  assign visible    = (px < 16'(H_DISPLAY)) && (py < 16'(V_DISPLAY));
  assign in_banner  = (px >= 16'(BANNER_X0)) && (px <= 16'(BANNER_X1)) &&
                      (py >= 16'(BANNER_Y0)) && (py <= 16'(BANNER_Y1));
  assign in_bar_row = (py >= 16'(BAR_Y0)) && (py <= 16'(BAR_Y1));
  assign in_bar_l   = in_bar_row && (px >= 16'(BANNER_X0)) && (px < bar_l_end);
  assign in_bar_r   = in_bar_row && (px >= bar_r_start) && (px <= 16'(BANNER_X1));

`ifdef ENDSCREEN_BORDER_EN
  assign in_border = (px < 16'(BORDER_W)) || (px >= 16'(H_DISPLAY - BORDER_W)) ||
                     (py < 16'(BORDER_W)) || (py >= 16'(V_DISPLAY - BORDER_W));
`else
  assign in_border = 1'b0;
`endif

  always_comb begin
    case (res_q)
      RES_WIN:  banner_rgb = 12'h0F0;
      RES_LOSE: banner_rgb = 12'hF00;
      default:  banner_rgb = 12'hFF0;
    endcase
  end

  always_comb begin
    rgb_d      = 12'h000;
    video_on_d = visible;
    hsync_d    = !((px >= 16'(H_DISPLAY + H_FP)) && (px <= 16'(H_DISPLAY + H_FP + H_SYNC - 1)));
    vsync_d    = !((py >= 16'(V_DISPLAY + V_FP)) && (py <= 16'(V_DISPLAY + V_FP + V_SYNC - 1)));
    if (visible && state_q == S_SHOW) begin
      if (in_border)                 rgb_d = 12'hFFF;
      else if (in_banner)            rgb_d = blink_on_q ? banner_rgb : 12'h008;
      else if (in_bar_l || in_bar_r) rgb_d = 12'hFFF;
      else                           rgb_d = 12'h008;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      state_q     <= S_IDLE;
      res_q       <= RES_WIN;
      en_q        <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      rgb_q       <= 12'h000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      video_on_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      x_q         <= x_d;
      y_q         <= y_d;
      state_q     <= state_d;
      res_q       <= res_d;
      en_q        <= en_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      // Pixel outputs move once per pixel, one pixel behind the counters.
      if (p_tick) begin
        rgb_q      <= rgb_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
      end
    end
  end

  assign rgb      = rgb_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
  assign done     = (state_q == S_EXIT);

endmodule

// File: tb/tb_endscreen_vga_ctrl.sv
// Testbench for endscreen_vga_ctrl on a reduced display geometry (40x28
// total, 32x24 visible, 2 clocks per pixel) so that whole frames fit in a
// short run. Pixel expectations go into a scoreboard keyed by frame/x/y;
// the bench derives the displayed pixel from its own clock count.

module tb_endscreen_vga_ctrl;

  localparam int CD = 2;
  localparam int HD = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VD = 24, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HD + HFP + HS + HBP;   // 40
  localparam int VT = VD + VFP + VS + VBP;   // 28
  localparam int FP = HT * VT;               // pixels per frame
  localparam int FC = FP * CD;               // clocks per frame

`ifdef ENDSCREEN_BORDER_EN
  localparam logic [11:0] CORNER_EXP = 12'hFFF;
`else
  localparam logic [11:0] CORNER_EXP = 12'h008;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, win = 1'b0, lose = 1'b0, home = 1'b0;
  logic [3:0]  score_l = 4'd0, score_r = 4'd0;
  logic [11:0] rgb;
  logic        hsync, vsync, video_on, frame_tick, done;

  endscreen_vga_ctrl #(
    .CLK_DIV(CD), .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .BLINK_FRAMES(1), .TIMEOUT_FRAMES(4), .SCORE_W(4),
    .BANNER_X0(4), .BANNER_X1(27), .BANNER_Y0(8), .BANNER_Y1(11),
    .BAR_Y0(13), .BAR_Y1(14), .BAR_UNIT(2), .BORDER_W(8)
  ) dut (
    .clk_100MHz(clk), .reset(reset), .enable(enable), .win(win), .lose(lose),
    .home(home), .score_l(score_l), .score_r(score_r), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_tick(frame_tick), .done(done)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; the DUT counters advance on exactly these edges.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          key;
    logic [11:0] rgb;
    string       name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;

  task automatic push(input int fr, input int x, input int y, input logic [11:0] e, input string n);
    exp_t t;
    t.key  = fr * FP + y * HT + x;
    t.rgb  = e;
    t.name = n;
    sb.push_back(t);
  endtask

  // One clock; samples on the falling edge, logs done pulses and retires
  // scoreboard entries whose pixel is on the output now.
  task automatic tick();
    int   dp;
    exp_t h;
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (!reset && cyc >= CD && (cyc % CD) == 0) begin
      dp = cyc / CD - 1;
      while (sb.size() > 0 && sb[0].key < dp) begin
        h = sb.pop_front();
        total++; bad++;
        $display("FAIL %s: pixel (%0d,%0d) never sampled, required %h", h.name,
                 (h.key % FP) % HT, (h.key % FP) / HT, h.rgb);
      end
      if (sb.size() > 0 && sb[0].key == dp) begin
        h = sb.pop_front();
        total++;
        if (rgb !== h.rgb) begin
          bad++;
          $display("FAIL %s: pixel (%0d,%0d) rgb=%h required=%h", h.name,
                   (h.key % FP) % HT, (h.key % FP) / HT, rgb, h.rgb);
        end else begin
          $display("pixel %s (%0d,%0d) rgb=%h ok", h.name, (h.key % FP) % HT, (h.key % FP) / HT, rgb);
        end
      end
    end
  endtask

  task automatic goto_cyc(input int t);
    int g = 0;
    while (cyc < t && g < 200000) begin
      tick();
      g++;
    end
    total++;
    if (cyc != t) begin
      bad++;
      $display("FAIL goto_cyc: cyc=%0d required=%0d", cyc, t);
    end
  endtask

  task automatic wait_sb(input int budget);
    int g = 0;
    while (sb.size() > 0 && g < budget) begin
      tick();
      g++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL wait_sb: %0d pixels pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rgb !== 12'h000)   begin bad++; $display("FAIL reset_rgb: got %h required 000", rgb); end
    total++; if (hsync !== 1'b1)    begin bad++; $display("FAIL reset_hsync: got %b required 1", hsync); end
    total++; if (vsync !== 1'b1)    begin bad++; $display("FAIL reset_vsync: got %b required 1", vsync); end
    total++; if (video_on !== 1'b0) begin bad++; $display("FAIL reset_video_on: got %b required 0", video_on); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_frame_tick: got %b required 0", frame_tick); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    $display("reset outputs checked");
    reset = 1'b0;
  endtask

  task automatic test_timing();
    int ft_bad = 0, hs_bad = 0, vs_bad = 0, vo_bad = 0, rgb_bad = 0;
    int hs_low = 0, vs_low = 0, ft_cnt = 0, first_ft = -1;
    int dp, x, y;
    logic e_hs, e_vs, e_vo, e_ft;
    for (int i = 0; i < 2 * FC; i++) begin
      tick();
      if (cyc < CD) begin
        e_hs = 1'b1; e_vs = 1'b1; e_vo = 1'b0;
      end else begin
        dp   = cyc / CD - 1;
        x    = (dp % FP) % HT;
        y    = (dp % FP) / HT;
        e_hs = !(x >= HD + HFP && x < HD + HFP + HS);
        e_vs = !(y >= VD + VFP && y < VD + VFP + VS);
        e_vo = (x < HD) && (y < VD);
      end
      e_ft = ((cyc % FC) == FC - 1);
      if (frame_tick !== e_ft) ft_bad++;
      if (hsync !== e_hs) hs_bad++;
      if (vsync !== e_vs) vs_bad++;
      if (video_on !== e_vo) vo_bad++;
      if (rgb !== 12'h000) rgb_bad++;
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (frame_tick === 1'b1) begin
        ft_cnt++;
        if (first_ft < 0) first_ft = cyc;
      end
    end
    total++; if (ft_bad != 0)  begin bad++; $display("FAIL frame_tick_pattern: %0d wrong clocks required 0", ft_bad); end
    total++; if (hs_bad != 0)  begin bad++; $display("FAIL hsync_pattern: %0d wrong clocks required 0", hs_bad); end
    total++; if (vs_bad != 0)  begin bad++; $display("FAIL vsync_pattern: %0d wrong clocks required 0", vs_bad); end
    total++; if (vo_bad != 0)  begin bad++; $display("FAIL video_on_pattern: %0d wrong clocks required 0", vo_bad); end
    total++; if (rgb_bad != 0) begin bad++; $display("FAIL idle_rgb: %0d nonzero clocks required 0", rgb_bad); end
    total++; if (first_ft != FC - 1) begin bad++; $display("FAIL first_frame_tick: cyc=%0d required=%0d", first_ft, FC - 1); end
    total++; if (ft_cnt != 2) begin bad++; $display("FAIL frame_tick_count: got %0d required 2", ft_cnt); end
    total++; if (hs_low != 2 * VT * HS * CD) begin bad++; $display("FAIL hsync_low_clocks: got %0d required %0d", hs_low, 2 * VT * HS * CD); end
    total++; if (vs_low != 2 * VS * HT * CD) begin bad++; $display("FAIL vsync_low_clocks: got %0d required %0d", vs_low, 2 * VS * HT * CD); end
    $display("timing: first frame_tick at cyc %0d, hsync low %0d, vsync low %0d", first_ft, hs_low, vs_low);
  endtask

  // WIN session in frame 2, latched inputs, then enable dropped mid-line in frame 4.
  task automatic test_win_abort();
    goto_cyc(2 * FC + 10);
    win = 1'b1; lose = 1'b0; score_l = 4'd3; score_r = 4'd5; enable = 1'b1;
    push(2, 12, 9, 12'h0F0, "win_banner");
    push(2, 35, 9, 12'h000, "hblank_in_show");
    push(2, 9, 13, 12'hFFF, "bar_l_last");
    push(2, 10, 13, 12'h008, "bar_l_past");
    push(2, 14, 13, 12'h008, "bar_gap");
    push(2, 17, 13, 12'h008, "bar_r_before");
    push(2, 18, 13, 12'hFFF, "bar_r_first");
    push(2, 20, 13, 12'hFFF, "bar_r_mid");
    push(2, 3, 20, CORNER_EXP, "corner");
    push(3, 12, 9, 12'h008, "blink_off");
    push(3, 9, 13, 12'hFFF, "latched_bar_l");
    push(3, 10, 13, 12'h008, "latched_bar_l_end");
    push(4, 9, 9, 12'h0F0, "latched_result");
    push(4, 10, 9, 12'h000, "abort_blank");
    push(4, 20, 13, 12'h000, "abort_bar_blank");
    repeat (4) tick();
    win = 1'b0; lose = 1'b1; score_l = 4'd0; score_r = 4'd0;
    goto_cyc(4 * FC + (9 * HT + 10) * CD);
    enable = 1'b0;
    wait_sb(2 * FC);
    goto_cyc(5 * FC);
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done: pulses=%0d required 0", done_cnt); end
  endtask

  // DRAW session: banner blinks each frame, times out after the 4th frame_tick.
  task automatic test_blink_timeout();
    int d0;
    d0 = done_cnt;
    goto_cyc(5 * FC + 10);
    win = 1'b1; lose = 1'b1; score_l = 4'd1; score_r = 4'd1; enable = 1'b1;
    push(5, 12, 9, 12'hFF0, "draw_f0");
    push(6, 12, 9, 12'h008, "draw_f1");
    push(7, 12, 9, 12'hFF0, "draw_f2");
    push(8, 12, 9, 12'h008, "draw_f3");
    push(9, 12, 9, 12'h000, "after_timeout");
    push(9, 20, 13, 12'h000, "after_timeout_bar");
    wait_sb(6 * FC);
    total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL timeout_done_count: got %0d required %0d", done_cnt - d0, 1); end
    total++; if (last_done_cyc != 9 * FC) begin bad++; $display("FAIL timeout_done_cyc: got %0d required %0d", last_done_cyc, 9 * FC); end
  endtask

  // LOSE session left through home; enable held high must not restart;
  // a fresh enable edge starts a DRAW session with new scores.
  task automatic test_home_restart();
    int d0;
    goto_cyc(10 * FC + 10);
    enable = 1'b0;
    tick(); tick();
    win = 1'b0; lose = 1'b1; score_l = 4'd2; score_r = 4'd3; enable = 1'b1;
    push(10, 12, 9, 12'hF00, "lose_banner");
    push(10, 7, 13, 12'hFFF, "bar_l2_last");
    push(10, 8, 13, 12'h008, "bar_l2_past");
    push(10, 21, 13, 12'h008, "bar_r3_before");
    push(10, 22, 13, 12'hFFF, "bar_r3_first");
    push(11, 12, 9, 12'h008, "lose_blink_off");
    goto_cyc(12 * FC + 100);
    d0 = done_cnt;
    home = 1'b1;
    tick(); tick();
    home = 1'b0;
    push(12, 12, 9, 12'h000, "after_home");
    push(13, 12, 9, 12'h000, "no_restart");
    wait_sb(3 * FC);
    total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL home_done_count: got %0d required 1", done_cnt - d0); end
    total++; if (last_done_cyc != 12 * FC + 101) begin bad++; $display("FAIL home_done_cyc: got %0d required %0d", last_done_cyc, 12 * FC + 101); end
    goto_cyc(14 * FC + 10);
    enable = 1'b0;
    tick(); tick();
    win = 1'b0; lose = 1'b0; score_l = 4'd4; score_r = 4'd0; enable = 1'b1;
    push(14, 12, 9, 12'hFF0, "restart_banner");
    push(14, 11, 13, 12'hFFF, "restart_bar_l_last");
    push(14, 12, 13, 12'h008, "restart_bar_l_past");
    push(14, 23, 13, 12'h008, "restart_bar_r_empty");
    wait_sb(2 * FC);
  endtask

  // Reset while showing: outputs return to reset values at once, no done.
  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    reset = 1'b1;
    enable = 1'b0;
    #1;
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL midreset_rgb: got %h required 000", rgb); end
    total++; if (hsync !== 1'b1)  begin bad++; $display("FAIL midreset_hsync: got %b required 1", hsync); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL midreset_done: got %b required 0", done); end
    $display("mid-session reset outputs checked");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(0, 12, 9, 12'h000, "post_reset_idle");
    wait_sb(2 * FC);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL midreset_done_count: got %0d required 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_win_abort();
    test_blink_timeout();
    test_home_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
